decoder_issue_arbiter: RTL and testbench

Round-robin issue controller sharing one registered posit pair decoder (weight `win`, data `din`) among `NREQ` requesters. It accepts (win, din) pairs over per-requester valid/ready handshakes and registers the winning pair onto the decoder input. It returns a requester tag aligned cycle-exactly with the decoder's registered outputs. Issue is throttled by a credit counter against the downstream result buffer, because the decoder output stage cannot stall and carries no per-item valid.

---
 rtl/decoder_issue_arbiter.sv | 104 ++++++++++
 tb/tb_decoder_issue_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_issue_arbiter.sv
// decoder_issue_arbiter: round-robin, credit-throttled issue of posit pairs to a registered decoder with aligned response tags
// Ports:
//   clk_i, rstn                         clock, async active-low reset
//   req_vld_i/req_win_i/req_din_i       per-requester pair offers (packed k*WIDTH)
//   req_rdy_o                           one-hot combinational grant
//   dec_vld_o/dec_win_o/dec_din_o       registered decoder input stage
//   rsp_vld_o/rsp_tag_o                 requester tag aligned with decoder outputs
//   crd_ret_i/crd_cnt_o                 result-buffer credit return and count
//   busy_o, err_o                       pipeline occupancy, sticky credit overflow
module decoder_issue_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ = 4,
  parameter int LAT = 1,
  parameter int CREDITS = 4,
  localparam int TW = $clog2(NREQ),
  localparam int CW = $clog2(CREDITS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_vld_i,
  input  logic [NREQ*WIDTH-1:0] req_win_i,
  input  logic [NREQ*WIDTH-1:0] req_din_i,
  output logic [NREQ-1:0]       req_rdy_o,
  output logic                  dec_vld_o,
  output logic [WIDTH-1:0]      dec_win_o,
  output logic [WIDTH-1:0]      dec_din_o,
  output logic                  rsp_vld_o,
  output logic [TW-1:0]         rsp_tag_o,
  input  logic                  crd_ret_i,
  output logic [CW-1:0]         crd_cnt_o,
  output logic                  busy_o,
  output logic                  err_o
);
  logic [WIDTH-1:0] win_a [NREQ];
  logic [WIDTH-1:0] din_a [NREQ];
  logic [TW-1:0] ptr_q, ptr_d, gnt_idx, k, tag_q, tag_d;
  logic [CW-1:0] crd_q, crd_d;
  logic [WIDTH-1:0] win_q, win_d, din_q, din_d;
  logic gnt_any, issue, dec_vld_q, err_q, err_d;
  logic [LAT-1:0] stg_vld_q;
  logic [TW-1:0] stg_tag_q [LAT];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign win_a[g] = req_win_i[g*WIDTH +: WIDTH];
    assign din_a[g] = req_din_i[g*WIDTH +: WIDTH];
  end
  // Scan downward so the lowest rotation offset from ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    k = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = TW'((int'(ptr_q) + i) % NREQ);
      if (req_vld_i[k]) begin
        gnt_any = 1'b1;
        gnt_idx = k;
      end
    end
  end
  assign issue = gnt_any && crd_q != '0;
  assign req_rdy_o = issue ? NREQ'(1) << gnt_idx : '0;
  assign ptr_d = !issue ? ptr_q : gnt_idx == TW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
  assign win_d = issue ? win_a[gnt_idx] : win_q;
  assign din_d = issue ? din_a[gnt_idx] : din_q;
  assign tag_d = issue ? gnt_idx : tag_q;
  // A simultaneous issue and return cancel; a return into a full counter is an overflow.
  assign crd_d = issue && !crd_ret_i ? crd_q - 1'b1 :
                 crd_ret_i && !issue && crd_q != CW'(CREDITS) ? crd_q + 1'b1 : crd_q;
  assign err_d = err_q | (crd_ret_i & ~issue & (crd_q == CW'(CREDITS)));
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
      crd_q <= CW'(CREDITS);
      err_q <= 1'b0;
      dec_vld_q <= 1'b0;
      win_q <= '0;
      din_q <= '0;
      tag_q <= '0;
      stg_vld_q <= '0;
      for (int i = 0; i < LAT; i++) stg_tag_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      crd_q <= crd_d;
      err_q <= err_d;
      dec_vld_q <= issue;
      win_q <= win_d;
      din_q <= din_d;
      tag_q <= tag_d;
      stg_vld_q[0] <= dec_vld_q;
      stg_tag_q[0] <= tag_q;
      for (int i = 1; i < LAT; i++) begin
        stg_vld_q[i] <= stg_vld_q[i-1];
        stg_tag_q[i] <= stg_tag_q[i-1];
      end
    end
  end
  assign dec_vld_o = dec_vld_q;
  assign dec_win_o = win_q;
  assign dec_din_o = din_q;
  assign rsp_vld_o = stg_vld_q[LAT-1];
  assign rsp_tag_o = stg_tag_q[LAT-1];
  assign crd_cnt_o = crd_q;
  assign busy_o = dec_vld_q | (|stg_vld_q);
  assign err_o = err_q;
endmodule

// File: tb/tb_decoder_issue_arbiter.sv
// tb_decoder_issue_arbiter: history-based reference model with directed and random stimulus
module tb_decoder_issue_arbiter;
  localparam int WIDTH = 8, NREQ = 4, LAT = 1, CREDITS = 4, TW = 2, CW = 3, HN = 8192;
  logic clk_i = 0, rstn = 0;
  logic [NREQ-1:0] req_vld_i = '0;
  logic [NREQ*WIDTH-1:0] req_win_i = '0, req_din_i = '0;
  logic crd_ret_i = 0;
  logic [NREQ-1:0] req_rdy_o;
  logic dec_vld_o, rsp_vld_o, busy_o, err_o;
  logic [WIDTH-1:0] dec_win_o, dec_din_o;
  logic [TW-1:0] rsp_tag_o;
  logic [CW-1:0] crd_cnt_o;
  decoder_issue_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .CREDITS(CREDITS)) dut (
    .clk_i(clk_i), .rstn(rstn), .req_vld_i(req_vld_i), .req_win_i(req_win_i),
    .req_din_i(req_din_i), .req_rdy_o(req_rdy_o), .dec_vld_o(dec_vld_o),
    .dec_win_o(dec_win_o), .dec_din_o(dec_din_o), .rsp_vld_o(rsp_vld_o),
    .rsp_tag_o(rsp_tag_o), .crd_ret_i(crd_ret_i), .crd_cnt_o(crd_cnt_o),
    .busy_o(busy_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  int tests = 0, fails = 0;
  bit hv [HN];
  int ht [HN];
  int cyc = 0, rst_cyc = -1;
  int m_ptr = 0, m_cred = CREDITS, lw = 0, ld = 0;
  bit m_err = 0;
  logic [NREQ-1:0] m_gnt = '0;
  function automatic bit hval(input int i);
    return i > rst_cyc && i >= 0 && hv[i];
  endfunction
  function automatic bit rsp_due();
    return hval(cyc - 1 - LAT);
  endfunction
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic sample();
    logic [NREQ-1:0] er;
    int k;
    bit iss, bz;
    @(negedge clk_i);
    if (!rstn) begin
      rst_cyc = cyc;
      m_ptr = 0;
      m_cred = CREDITS;
      m_err = 0;
      lw = 0;
      ld = 0;
      m_gnt = '0;
      hv[cyc] = 0;
      check("rst_dec_vld", 32'(dec_vld_o), 0);
      check("rst_dec_win", 32'(dec_win_o), 0);
      check("rst_dec_din", 32'(dec_din_o), 0);
      check("rst_rsp_vld", 32'(rsp_vld_o), 0);
      check("rst_rsp_tag", 32'(rsp_tag_o), 0);
      check("rst_crd", 32'(crd_cnt_o), 32'(CREDITS));
      check("rst_err", 32'(err_o), 0);
      check("rst_busy", 32'(busy_o), 0);
    end else begin
      er = '0;
      if (m_cred > 0)
        for (int i = 0; i < NREQ; i++) begin
          k = (m_ptr + i) % NREQ;
          if (req_vld_i[k] && er == '0) er[k] = 1'b1;
        end
      check("rdy", 32'(req_rdy_o), 32'(er));
      check("dec_vld", 32'(dec_vld_o), 32'(hval(cyc - 1)));
      check("dec_win", 32'(dec_win_o), 32'(lw));
      check("dec_din", 32'(dec_din_o), 32'(ld));
      check("rsp_vld", 32'(rsp_vld_o), 32'(hval(cyc - 1 - LAT)));
      if (hval(cyc - 1 - LAT)) check("rsp_tag", 32'(rsp_tag_o), 32'(ht[cyc - 1 - LAT]));
      bz = 0;
      for (int i = cyc - 1 - LAT; i <= cyc - 1; i++) bz |= hval(i);
      check("busy", 32'(busy_o), 32'(bz));
      check("crd", 32'(crd_cnt_o), 32'(m_cred));
      check("err", 32'(err_o), 32'(m_err));
      iss = er != '0;
      hv[cyc] = iss;
      m_gnt = er;
      for (int i = 0; i < NREQ; i++)
        if (er[i]) begin
          ht[cyc] = i;
          lw = int'(req_win_i[i*WIDTH +: WIDTH]);
          ld = int'(req_din_i[i*WIDTH +: WIDTH]);
          m_ptr = (i + 1) % NREQ;
        end
      if (iss && !crd_ret_i) m_cred--;
      else if (crd_ret_i && !iss) begin
        if (m_cred == CREDITS) m_err = 1;
        else m_cred++;
      end
    end
    cyc++;
  endtask
  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drain();
    req_vld_i = '0;
    for (int i = 0; i < 8; i++) begin
      crd_ret_i = m_cred < CREDITS;
      sample();
      adv();
    end
    crd_ret_i = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n;
    rstn = 0;
    sample();
    adv();
    rstn = 1;
    for (int i = 0; i < 3; i++) begin sample(); adv(); end
    req_vld_i = 4'b0100;
    req_win_i[2*WIDTH +: WIDTH] = 8'h40;
    req_din_i[2*WIDTH +: WIDTH] = 8'hC0;
    sample();
    check("t2_rdy", 32'(req_rdy_o), 32'h4);
    adv();
    req_vld_i = '0;
    sample();
    check("t2_dec_vld", 32'(dec_vld_o), 1);
    check("t2_dec_win", 32'(dec_win_o), 32'h40);
    check("t2_dec_din", 32'(dec_din_o), 32'hC0);
    check("t2_crd", 32'(crd_cnt_o), 3);
    adv();
    sample();
    check("t2_rsp_vld", 32'(rsp_vld_o), 1);
    check("t2_rsp_tag", 32'(rsp_tag_o), 2);
    adv();
    drain();
    req_vld_i = '1;
    for (int i = 0; i < 10; i++) begin
      crd_ret_i = rsp_due();
      sample();
      if (i < 8) check("t3_order", 32'(req_rdy_o), 32'(1) << ((3 + i) % 4));
      adv();
    end
    crd_ret_i = 0;
    drain();
    req_vld_i = '1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      n += int'(req_rdy_o != '0);
      if (i == 7) begin
        check("t4_grants", 32'(n), 4);
        check("t4_rdy0", 32'(req_rdy_o), 0);
        check("t4_crd0", 32'(crd_cnt_o), 0);
      end
      adv();
    end
    crd_ret_i = 1;
    sample();
    check("t4_ret_cycle_rdy", 32'(req_rdy_o), 0);
    adv();
    crd_ret_i = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (i == 0) check("t4_next_grant", 32'(req_rdy_o != '0), 1);
      n += int'(req_rdy_o != '0);
      adv();
    end
    check("t4_one_more", 32'(n), 1);
    drain();
    req_vld_i = 4'b0001;
    for (int i = 0; i < 2; i++) begin sample(); adv(); end
    crd_ret_i = 1;
    sample();
    adv();
    crd_ret_i = 0;
    req_vld_i = '0;
    sample();
    check("t5_coincident_crd", 32'(crd_cnt_o), 2);
    adv();
    drain();
    crd_ret_i = 1;
    sample();
    adv();
    crd_ret_i = 0;
    sample();
    check("t5_ovf_crd", 32'(crd_cnt_o), 4);
    check("t5_ovf_err", 32'(err_o), 1);
    adv();
    for (int i = 0; i < 3; i++) begin sample(); adv(); end
    check("t5_err_sticky", 32'(err_o), 1);
    drain();
    req_vld_i = 4'b0010;
    sample();
    adv();
    req_vld_i = 4'b1010;
    sample();
    check("t6_grant3", 32'(req_rdy_o), 32'h8);
    adv();
    req_vld_i = 4'b0010;
    sample();
    check("t6_grant1", 32'(req_rdy_o), 32'h2);
    adv();
    req_vld_i = '0;
    sample();
    adv();
    sample();
    check("t6_rsp_vld", 32'(rsp_vld_o), 1);
    check("t6_rsp_tag", 32'(rsp_tag_o), 1);
    adv();
    for (int i = 0; i < 2; i++) begin
      sample();
      check("t6_busy_low", 32'(busy_o), 0);
      adv();
    end
    drain();
    req_vld_i = '1;
    for (int i = 0; i < 2; i++) begin sample(); adv(); end
    rstn = 0;
    sample();
    check("t7_rst_crd", 32'(crd_cnt_o), 4);
    adv();
    rstn = 1;
    req_vld_i = '0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t7_no_rsp", 32'(rsp_vld_o), 0);
      adv();
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NREQ; k++)
        if (m_gnt[k] || !req_vld_i[k]) begin
          req_vld_i[k] = ($urandom % 4) != 0;
          req_win_i[k*WIDTH +: WIDTH] = WIDTH'($urandom);
          req_din_i[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      crd_ret_i = m_cred < CREDITS ? ($urandom % 3) == 0 : ($urandom % 64) == 0;
      rstn = ($urandom % 400) != 0;
      sample();
      adv();
      rstn = 1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
